// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic inter-stage pipeline register (D/E, E/M, M/W). It carries one
// packed payload per beat. Stalls propagate backward through in_ready, so
// no central stall net is needed. A synchronous flush kills every held beat
// and zeroes the control field. SKID=1 selects a two-entry skid buffer with
// a registered in_ready. A saturating counter records downstream stall
// cycles.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. The sender must not make valid depend on ready.
// Beats leave in the order they were accepted.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   flush        synchronous kill of held beats and of the presented input
//   in_valid     upstream beat present
//   in_ready     stage can accept a beat this cycle
//   in_data      upstream payload, control in [DATA_W-1 -: CTRL_W]
//   out_valid    downstream beat present
//   out_ready    downstream accepts out_data this cycle
//   out_data     head payload (control field zero while out_valid=0)
//   occupancy    number of held beats (0..2)
//   stall_cycles saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int DATA_W = 165,
    parameter int CTRL_W = 17,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // DATA_MASK keeps the data field and clears the control field.
    // Shifting by CTRL_W covers both edge cases: CTRL_W=0 keeps every bit,
    // and CTRL_W=DATA_W clears every bit.
    localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_MASK = ALL_ONES >> CTRL_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = m_valid & out_ready;
    assign out_valid = m_valid;
    // A bubble shows the retained data field with the control field zeroed.
    assign out_data  = m_valid ? m_data : (m_data & DATA_MASK);
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] s_data;

            // S is the only state that can block input. This keeps in_ready
            // a register output, so no combinational path runs from
            // out_ready to in_ready.
            assign in_ready = ~s_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                    m_data  <= '0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                    m_data  <= m_data & DATA_MASK;
                    s_data  <= s_data & DATA_MASK;
                end else if (out_xfer && s_valid) begin
                    // Promote the skid entry. in_ready is low here, so no
                    // input can arrive in the same cycle.
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                end else if (in_xfer) begin
                    if (!m_valid || out_xfer) begin
                        m_valid <= 1'b1;
                        m_data  <= in_data;
                    end else begin
                        s_valid <= 1'b1;
                        s_data  <= in_data;
                    end
                end else if (out_xfer) begin
                    m_valid <= 1'b0;
                end
            end
        end else begin : g_single
            assign s_valid  = 1'b0;
            assign in_ready = out_ready | ~m_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_data  <= m_data & DATA_MASK;
                end else if (in_xfer) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else if (out_xfer) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Flush does not touch the counter. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (m_valid && !out_ready && stall_cycles != CNT_MAX) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic. Two lanes run side by side: lane 0 is
// SKID=0 and lane 1 is SKID=1. They share out_ready, flush and a beat
// generator. Each lane has its own upstream source queue and scoreboard.
module tb_pipe_stage_elastic;
  localparam int W  = 16;
  localparam int CW = 4;
  localparam int CN = 4;
  localparam logic [W-1:0]  DMASK = 16'h0FFF;
  localparam logic [CN-1:0] SMAX  = 4'hF;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic gen_en = 1'b0;
  logic [W-1:0] gen_data = '0;

  logic          ir_a  [2];
  logic          ov_a  [2];
  logic [W-1:0]  od_a  [2];
  logic [1:0]    occ_a [2];
  logic [CN-1:0] sc_a  [2];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Sets the shared inputs for the cycle that follows this negedge.
  task automatic step(input logic ge, input logic [W-1:0] gd, input logic ordy, input logic fl);
    @(negedge clk);
    gen_en = ge;
    gen_data = gd;
    out_ready = ordy;
    flush = fl;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  src_q[$];
    logic [W-1:0]  exp_q[$];
    logic          rdy_m = 1'b1;
    logic          acc = 1'b0;
    logic [CN-1:0] stall_exp = '0;
    logic [W-1:0]  last_head = '0;

    pipe_stage_elastic #(.DATA_W(W), .CTRL_W(CW), .SKID(g), .CNT_W(CN)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir_a[g]), .in_data(in_data),
      .out_valid(ov_a[g]), .out_ready(out_ready), .out_data(od_a[g]),
      .occupancy(occ_a[g]), .stall_cycles(sc_a[g])
    );

    // Driver: presents the head of the source queue. The reference model
    // treats the stage as a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    // At the edge it pushes accepted beats into the scoreboard.
    always begin
      @(negedge clk);
      #1;
      if (reset) begin
        src_q.delete();
        in_valid = 1'b0;
        acc = 1'b0;
      end else begin
        if (gen_en) src_q.push_back(gen_data);
        in_valid = (src_q.size() > 0);
        in_data = in_valid ? src_q[0] : '0;
        rdy_m = (g == 1) ? (exp_q.size() < 2) : (out_ready || exp_q.size() == 0);
        acc = in_valid && rdy_m;
      end
      @(posedge clk);
      if (reset || flush) begin
        exp_q.delete();
        src_q.delete();
      end else if (acc) begin
        exp_q.push_back(src_q.pop_front());
      end
    end

    // Monitor: compares the outputs, pops delivered beats and tracks the
    // expected stall count.
    always begin
      @(negedge clk);
      #2;
      if (reset) begin
        stall_exp = '0;
        last_head = '0;
      end else begin
        check($sformatf("lane%0d out_valid", g), W'(ov_a[g]), W'(exp_q.size() > 0));
        check($sformatf("lane%0d occupancy", g), W'(occ_a[g]), W'(exp_q.size()));
        check($sformatf("lane%0d in_ready", g), W'(ir_a[g]), W'(rdy_m));
        check($sformatf("lane%0d stall_cycles", g), W'(sc_a[g]), W'(stall_exp));
        if (exp_q.size() > 0) begin
          check($sformatf("lane%0d out_data", g), od_a[g], exp_q[0]);
          last_head = exp_q[0];
          if (out_ready) void'(exp_q.pop_front());
          else if (stall_exp != SMAX) stall_exp++;
        end else begin
          check($sformatf("lane%0d bubble", g), od_a[g], last_head & DMASK);
        end
      end
    end
  end

  initial begin
    // reset state
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d out_valid", i), W'(ov_a[i]), '0);
      check($sformatf("rst%0d out_data", i), od_a[i], '0);
      check($sformatf("rst%0d occupancy", i), W'(occ_a[i]), '0);
      check($sformatf("rst%0d stall", i), W'(sc_a[i]), '0);
      check($sformatf("rst%0d in_ready", i), W'(ir_a[i]), W'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b0;

    // streaming 1..8
    for (int k = 1; k <= 8; k++) step(1'b1, W'(k), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) check($sformatf("stream%0d stall", i), W'(sc_a[i]), '0);

    // backpressure A,B,C
    step(1'b1, 16'h000A, 1'b1, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #3;
    check("bp skid occupancy", W'(occ_a[1]), W'(2));
    check("bp skid in_ready", W'(ir_a[1]), '0);
    check("bp single in_ready", W'(ir_a[0]), '0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) check($sformatf("bp%0d stall", i), W'(sc_a[i]), W'(3));

    // flush while full, with an all-ones beat presented
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("flush%0d out_valid", i), W'(ov_a[i]), '0);
      check($sformatf("flush%0d occupancy", i), W'(occ_a[i]), '0);
      check($sformatf("flush%0d in_ready", i), W'(ir_a[i]), W'(1));
      check($sformatf("flush%0d out_data", i), od_a[i], 16'h0234);
    end
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // counter saturation
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) check($sformatf("sat%0d stall", i), W'(sc_a[i]), W'(15));
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) check($sformatf("satflush%0d stall", i), W'(sc_a[i]), W'(15));
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    step(1'b1, 16'h7111, 1'b0, 1'b0);
    step(1'b1, 16'h7222, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #3;
    check("pre-reset skid occupancy", W'(occ_a[1]), W'(2));
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("arst%0d out_valid", i), W'(ov_a[i]), '0);
      check($sformatf("arst%0d out_data", i), od_a[i], '0);
      check($sformatf("arst%0d occupancy", i), W'(occ_a[i]), '0);
      check($sformatf("arst%0d stall", i), W'(sc_a[i]), '0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;

    // randomized traffic
    repeat (400)
      step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 4);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    #3;
    for (int i = 0; i < 2; i++) check($sformatf("drain%0d occupancy", i), W'(occ_a[i]), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic inter-stage pipeline register for the CPU pipeline (D/E, E/M, M/W). It carries one packed payload per beat with a valid/ready handshake, so stalls propagate backward without a central stall net. It provides synchronous flush with control-field bubble insertion. An optional two-entry skid buffer keeps full throughput with a registered in_ready. A saturating stall counter supports performance debug.

Parameters:
DATA_W, 165, total payload width in bits
CTRL_W, 17, number of most-significant payload bits treated as control; zeroed on bubble or flush; must be 0..DATA_W
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held beats and of any input presented this cycle
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat this cycle
in_data  in  DATA_W  upstream payload; control bits in [DATA_W-1 : DATA_W-CTRL_W]
out_valid  out  1  downstream beat present
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  DATA_W  head payload
occupancy  out  2  number of held beats (0..2; max 1 when SKID=0)
stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, active-high): all valid bits 0, both payload registers 0, stall_cycles 0. Consequently out_valid=0, out_data=0 and occupancy=0. in_ready is 1 while in reset.
- Handshake transfer rules:
  - Input transfer occurs when in_valid and in_ready are both high.
  - Output transfer occurs when out_valid and out_ready are both high.
  - Beats leave in acceptance order. No duplication, no loss, except on flush.
- Latency: an input accepted into an empty stage appears on out_valid/out_data on the next cycle.
- Bubble output: when out_valid=0, out_data control field = 0. The data field below the control field holds its last value.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - The single register loads in_data on an input transfer.
  - out_valid clears on an output transfer with no concurrent input transfer.
- SKID=1:
  - Main register M drives the output; skid register S backs it up.
  - in_ready = ~S.valid, from a register only.
  - Input transfer while M is empty, or while M is draining this cycle with S empty: load M.
  - Input transfer while M is held (out_ready=0): load S.
  - Output transfer with S valid: move S to M and clear S. A simultaneous input transfer is impossible in this case, because in_ready=0.
  - Full throughput is 1 beat/cycle with out_ready held high.
- occupancy = M.valid + S.valid.
- Flush:
  - Synchronous; it has priority over every other event in the same cycle.
  - Clears M.valid and S.valid; any concurrent input beat is dropped.
  - The control fields of both registers are zeroed; data fields are retained.
  - In the next cycle out_valid=0, occupancy=0 and in_ready=1.
  - A flush coinciding with out_ready=1 still counts the head as delivered downstream in that cycle; the stage does not retract it.
- stall_cycles:
  - Increments when out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not affect it.
- Degenerate widths:
  - CTRL_W=0 means no field is zeroed.
  - CTRL_W=DATA_W means the whole payload is zeroed on bubble or flush.

Test Plan:
- Reset mid-stream: SKID=1, two beats held, assert reset asynchronously between edges -> out_valid=0, out_data=0, occupancy=0 and stall_cycles=0 immediately, before the next edge.
- Streaming: in_valid=1 with payloads 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, each one cycle after its acceptance; occupancy stays at 1; stall_cycles=0.
- Backpressure, SKID=1: stream 0xA,0xB,0xC and drop out_ready for 3 cycles -> occupancy reaches 2 and in_ready falls to 0. With out_ready restored -> output is exactly A,B,C in order and stall_cycles=3.
- Backpressure, SKID=0: same stimulus -> in_ready follows out_ready combinationally, no beat is lost, output order is preserved.
- Flush with input: stage full (2 beats) and flush=1 with in_valid=1 (in_data=all-ones) in the same cycle -> next cycle out_valid=0, occupancy=0, out_data control field=0; the dropped beat never appears.
- Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 and stays at 15; a subsequent flush leaves it at 15.
